num_burst_tx: RTL
=================

# num_burst_tx

Sample-burst transmitter that produces the NUM/ADD stream consumed by the averaging receiver. It buffers 4-bit samples from a host-side write port. It transmits each batch as a burst of consecutive ADD=1 cycles, then one ADD=0 commit cycle that makes the receiver latch its average. It also reports the floor average it sent, so a checker can compare against the receiver's AVE.

## Interface
Parameters:
- W, 4, sample width (matches receiver NUM)
- DEPTH, 8, buffer depth and full-burst length; power of two; also the fixed divisor for EXP_AVE

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- WR_EN  in  1  write strobe for WR_DATA
- WR_DATA  in  W  sample to enqueue
- FLUSH  in  1  start a short burst with whatever is buffered (level, sampled in IDLE)
- FULL  out  1  buffer holds DEPTH samples (registered)
- OVF  out  1  sticky: a write was dropped because FULL was 1
- BUSY  out  1  state is SEND or COMMIT
- NUM  out  W  sample to receiver
- ADD  out  1  1 = NUM is a valid sample; 0 = commit/idle
- DONE  out  1  one-cycle pulse in the COMMIT cycle
- EXP_AVE  out  W  sum of last burst / DEPTH, floor

## Operation
- Reset: state IDLE, buffer empty, NUM=0, ADD=0, DONE=0, FULL=0, OVF=0, BUSY=0, EXP_AVE=0. RST overrides every other input that cycle.
- Buffer: circular FIFO, DEPTH entries, count width $clog2(DEPTH)+1.
  - A write is accepted iff WR_EN && !FULL.
  - WR_EN && FULL drops the sample and sets OVF.
  - Writes are allowed in every state. A write and a pop in the same cycle are both performed.
  - Pointers wrap modulo DEPTH.
- States:
  - IDLE: ADD=0, NUM holds last value.
    - If count==DEPTH: go to SEND with L=DEPTH.
    - Else if FLUSH && count>0: go to SEND with L=count.
    - FLUSH with an empty buffer is ignored.
  - SEND: pop one sample per cycle; drive it on NUM with ADD=1; accumulate it into a sum of width W+$clog2(DEPTH). After L pops, go to COMMIT.
    - Samples written during SEND are not part of the current burst.
  - COMMIT: one cycle with ADD=0 and DONE=1; EXP_AVE ← sum >> $clog2(DEPTH); sum cleared. Go to IDLE.
- Division is always by DEPTH, including short FLUSH bursts, because the receiver divides by 8 unconditionally.
- Reset mid-burst aborts: ADD=0 from the next edge; the remaining samples and the partial sum are discarded, with no DONE.

## Timing
- All outputs are registered and change only on rising CLK. They are therefore stable at the falling edge, where the receiver samples.
- Trigger seen in IDLE at edge t → first sample with ADD=1 from edge t+1.
- The burst occupies edges t+1..t+L. COMMIT starts at edge t+L+1. IDLE resumes at edge t+L+2.
- Minimum ADD=0 gap between bursts: 2 cycles (COMMIT plus one IDLE evaluation cycle).
- FULL updates the edge after the accepting write or pop.
- EXP_AVE updates at the same edge DONE rises and holds until the next COMMIT.

## Structure
- Shared package: the state enum (IDLE, SEND, COMMIT) and default W/DEPTH constants, shared with the receiver bench.
- Sub-module num_fifo (parameters W, DEPTH): write port, pop strobe, data out, count, full/empty.
- The top level holds the FSM, burst counter, sum and output registers.

## Test plan
- Write 1..8 → 8 cycles of ADD=1 with NUM=1,2,…,8; then one cycle ADD=0 with DONE=1; EXP_AVE=4 (36/8).
- Write 15 eight times → EXP_AVE=15. Nine writes in total while IDLE → ninth dropped, OVF=1, FULL=1 before the burst.
- Write 7, 9, then FLUSH → 2 ADD=1 cycles (7, 9), then COMMIT; EXP_AVE=2 (16/8).
- During a full burst, write 3 samples → current burst is exactly 8 samples. Afterwards count=3; FLUSH sends those 3 with a ≥2-cycle ADD=0 gap.
- Assert RST on the 4th ADD=1 cycle → next edge ADD=0, NUM=0, no DONE, EXP_AVE=0, buffer empty.
- FLUSH with an empty buffer → no state change, ADD stays 0, BUSY=0.

Source files
------------

// File: rtl/num_burst_tx_pkg.sv
// num_burst_tx_pkg: burst FSM states and default sizing shared with the receiver bench
package num_burst_tx_pkg;
   typedef enum logic [1:0] {IDLE, SEND, COMMIT} state_t;
   localparam int W_DEF = 4;
   localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/num_burst_tx_if.sv
// num_burst_tx_if: host write port plus the NUM/ADD stream and status toward the receiver
interface num_burst_tx_if import num_burst_tx_pkg::*; #(parameter int W = W_DEF);
   logic         WR_EN;
   logic [W-1:0] WR_DATA;
   logic         FLUSH;
   logic         FULL;
   logic         OVF;
   logic         BUSY;
   logic [W-1:0] NUM;
   logic         ADD;
   logic         DONE;
   logic [W-1:0] EXP_AVE;
   modport master (output WR_EN, WR_DATA, FLUSH, input FULL, OVF, BUSY, NUM, ADD, DONE, EXP_AVE);
   modport slave (input WR_EN, WR_DATA, FLUSH, output FULL, OVF, BUSY, NUM, ADD, DONE, EXP_AVE);
endinterface

// File: rtl/num_burst_tx_fifo.sv
// num_fifo: circular sample buffer; drops writes when full, pop must only be issued when non-empty
module num_fifo import num_burst_tx_pkg::*; #(
   parameter int W = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [W-1:0]           wr_data,
   input  logic                   pop,
   output logic [W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr;
   assign wr = wr_en && !full;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign rd_data = mem[rp];
   always_ff @(posedge clk)
      if (wr) mem[wp] <= wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/num_burst_tx.sv
// num_burst_tx: sends buffered samples as an ADD=1 burst followed by one ADD=0 commit cycle
module num_burst_tx import num_burst_tx_pkg::*; #(
   parameter int W = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input logic          CLK,
   input logic          RST,
   num_burst_tx_if.slave bus
);
   localparam int LG = $clog2(DEPTH);
   localparam int CW = LG + 1;
   state_t state, state_n;
   logic [CW-1:0] count, rem, rem_n;
   logic [W-1:0] rd_data;
   logic [W+LG-1:0] sum;
   logic pop, full, empty;
   num_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk(CLK), .rst(RST), .wr_en(bus.WR_EN), .wr_data(bus.WR_DATA), .pop(pop),
      .rd_data(rd_data), .count(count), .full(full), .empty(empty)
   );
   assign bus.FULL = full;
   assign bus.BUSY = state != IDLE;
   // burst length is latched at the trigger so samples written mid-burst wait for the next one
   always_comb begin
      state_n = state;
      rem_n = rem;
      pop = 1'b0;
      case (state)
         IDLE:
            if (count == CW'(DEPTH)) begin
               state_n = SEND;
               rem_n = CW'(DEPTH);
            end else if (bus.FLUSH && !empty) begin
               state_n = SEND;
               rem_n = count;
            end
         SEND: begin
            pop = 1'b1;
            rem_n = rem - CW'(1);
            state_n = rem == CW'(1) ? COMMIT : SEND;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         rem <= '0;
         sum <= '0;
         bus.NUM <= '0;
         bus.ADD <= 1'b0;
         bus.DONE <= 1'b0;
         bus.EXP_AVE <= '0;
         bus.OVF <= 1'b0;
      end else begin
         state <= state_n;
         rem <= rem_n;
         bus.ADD <= pop;
         bus.DONE <= state == COMMIT;
         if (pop) begin
            bus.NUM <= rd_data;
            sum <= sum + (W+LG)'(rd_data);
         end
         // receiver always divides by DEPTH, so short bursts are averaged the same way
         if (state == COMMIT) begin
            bus.EXP_AVE <= W'(sum >> LG);
            sum <= '0;
         end
         if (bus.WR_EN && full) bus.OVF <= 1'b1;
      end
   end
endmodule
